// File: rtl/bist_pattern_compactor.sv
// rtl/bist_pattern_compactor.sv - LFSR pattern source and MISR response compactor with golden compare.
// Optional X-masking of CUT responses is enabled by defining BIST_X_MASK_EN.
module bist_pattern_compactor #(
  parameter int          PAT_W         = 3,
  parameter int          RSP_W         = 6,
  parameter int          PATTERN_COUNT = 255,
  parameter int          LATENCY       = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter logic [15:0] MISR_SEED     = 16'h0000,
  parameter logic [15:0] GOLDEN        = 16'h0000
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             START,
  output logic [PAT_W-1:0] PAT,
  input  logic [RSP_W-1:0] RSP,
`ifdef BIST_X_MASK_EN
  input  logic [RSP_W-1:0] RSP_MASK,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [15:0]      SIG
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_APPLY, S_DRAIN, S_DONE} state_t;

  localparam logic [15:0] PC16  = 16'(PATTERN_COUNT);
  localparam logic [3:0]  LAT4  = 4'(LATENCY);
  localparam state_t      AFTER_APPLY = (LATENCY == 0) ? S_DONE : S_DRAIN;

  state_t      state, state_d;
  logic [15:0] lfsr, lfsr_d;
  logic [15:0] misr, misr_d;
  logic [15:0] cnt, cnt_d;
  logic [3:0]  dcnt, dcnt_d;
  logic        pass_r, pass_d;

  logic [RSP_W-1:0] rsp_eff;
  logic [15:0]      lfsr_step;
  logic [15:0]      misr_step;
  logic [16:0]      apply_diff;
  logic [17:0]      drain_diff;

`ifdef BIST_X_MASK_EN
  assign rsp_eff = RSP & ~RSP_MASK;
`else
  assign rsp_eff = RSP;
`endif

  assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign misr_step = {misr[14:0], misr[15] ^ misr[13] ^ misr[12] ^ misr[10]} ^ 16'(rsp_eff);

  // Response to pattern k arrives LATENCY cycles after it is applied; sign bits mark "not yet".
  assign apply_diff = {1'b0, cnt} - 17'(LATENCY);
  assign drain_diff = 18'(PATTERN_COUNT) + 18'(dcnt) - 18'(LATENCY);

  always_comb begin
    state_d = state;
    lfsr_d  = lfsr;
    misr_d  = misr;
    cnt_d   = cnt;
    dcnt_d  = dcnt;
    pass_d  = pass_r;
    case (state)
      S_IDLE: begin
        if (START) state_d = S_INIT;
      end
      S_INIT: begin
        lfsr_d = LFSR_SEED;
        misr_d = MISR_SEED;
        cnt_d  = '0;
        dcnt_d = '0;
        pass_d = 1'b0;
        state_d = (PATTERN_COUNT == 0) ? AFTER_APPLY : S_APPLY;
      end
      S_APPLY: begin
        lfsr_d = lfsr_step;
        cnt_d  = cnt + 16'd1;
        if (!apply_diff[16]) misr_d = misr_step;
        if (cnt == PC16 - 16'd1) state_d = AFTER_APPLY;
      end
      S_DRAIN: begin
        dcnt_d = dcnt + 4'd1;
        if (!drain_diff[17]) misr_d = misr_step;
        if (dcnt_d == LAT4) state_d = S_DONE;
      end
      S_DONE: begin
        if (START) state_d = S_INIT;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE && state != S_DONE) pass_d = (misr_d == GOLDEN);
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state  <= S_IDLE;
      lfsr   <= LFSR_SEED;
      misr   <= MISR_SEED;
      cnt    <= '0;
      dcnt   <= '0;
      pass_r <= 1'b0;
    end else begin
      state  <= state_d;
      lfsr   <= lfsr_d;
      misr   <= misr_d;
      cnt    <= cnt_d;
      dcnt   <= dcnt_d;
      pass_r <= pass_d;
    end
  end

  assign PAT  = lfsr[PAT_W-1:0];
  assign BUSY = (state == S_INIT) || (state == S_APPLY) || (state == S_DRAIN);
  assign DONE = (state == S_DONE);
  assign PASS = pass_r && (state == S_DONE);
  assign SIG  = misr;

endmodule

// File: tb/tb_bist_pattern_compactor.sv
// tb/tb_bist_pattern_compactor.sv - scoreboard bench over several parameterisations of bist_pattern_compactor.
module tb_bist_pattern_compactor;

  localparam int N = 7;
  localparam int          PCS    [N] = '{255, 4, 1, 1, 1, 6, 0};
  localparam int          LATS   [N] = '{1, 0, 0, 0, 2, 3, 2};
  localparam logic [15:0] LSEEDS [N] = '{16'hACE1, 16'hACE1, 16'hACE1, 16'hACE1, 16'hACE1, 16'h1234, 16'hACE1};
  localparam logic [15:0] MSEEDS [N] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h5A5A, 16'hBEEF};
  localparam logic [15:0] GOLDS  [N] = '{16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'hBEEF};

  logic          ck;
  logic          rstn;
  logic [N-1:0]  start;
  logic [5:0]    rsp [N];
  logic [5:0]    mask_v;
  logic [2:0]    pat [N];
  logic [15:0]   sig [N];
  logic [N-1:0]  busy, done, pass;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0]  stim [0:299];
  logic [15:0] exp_sig_q [$];
  logic        exp_pass_q [$];
  logic [2:0]  exp_pat_q [$];

  for (genvar g = 0; g < N; g++) begin : g_dut
    bist_pattern_compactor #(
      .PAT_W(3), .RSP_W(6), .PATTERN_COUNT(PCS[g]), .LATENCY(LATS[g]),
      .LFSR_SEED(LSEEDS[g]), .MISR_SEED(MSEEDS[g]), .GOLDEN(GOLDS[g])
    ) u_dut (
      .CK(ck), .RSTN(rstn), .START(start[g]), .PAT(pat[g]), .RSP(rsp[g]),
`ifdef BIST_X_MASK_EN
      .RSP_MASK(mask_v),
`endif
      .BUSY(busy[g]), .DONE(done[g]), .PASS(pass[g]), .SIG(sig[g])
    );
  end

  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [15:0] mstep(input logic [15:0] m, input logic [5:0] r);
    return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {10'b0, r};
  endfunction

  // kind: 0 zeros, 1 constant 1, 2 fresh random, 3 reuse previous stim, 4 all ones
  task automatic run(input int id, input int kind, input int abort_at);
    int          pc;
    int          lat;
    int          last;
    int          busy_n;
    logic [15:0] m;
    logic [15:0] l;
    pc     = PCS[id];
    lat    = LATS[id];
    last   = pc + lat + 1;
    busy_n = 0;
    if (kind != 3) begin
      for (int j = 0; j <= last + 1; j++)
        stim[j] = (kind == 0) ? 6'h00 : (kind == 1) ? 6'h01 : (kind == 4) ? 6'h3F : 6'($urandom);
    end
    m = MSEEDS[id];
    for (int k = 0; k < pc; k++) m = mstep(m, stim[1 + k + lat] & ~mask_v);
    exp_sig_q.push_back(m);
    exp_pass_q.push_back(m == GOLDS[id]);
    l = LSEEDS[id];
    for (int k = 0; k < pc; k++) begin
      exp_pat_q.push_back(l[2:0]);
      l = lstep(l);
    end
    @(posedge ck); #1 start[id] = 1'b1;
    @(posedge ck); #1 start[id] = 1'b0;
    rsp[id] = stim[0];
    for (int j = 0; j <= last; j++) begin
      @(negedge ck);
      if (j == abort_at) begin
        rstn = 1'b0;
        #1;
        l = LSEEDS[id];
        check("abort_busy", busy[id], 1'b0);
        check("abort_done", done[id], 1'b0);
        check("abort_sig", sig[id], MSEEDS[id]);
        check("abort_pat", pat[id], l[2:0]);
        exp_sig_q.delete();
        exp_pass_q.delete();
        exp_pat_q.delete();
        @(negedge ck) rstn = 1'b1;
        return;
      end
      if (busy[id]) busy_n++;
      if (j == 0) begin
        check("init_busy", busy[id], 1'b1);
        check("init_done", done[id], 1'b0);
        check("init_pass", pass[id], 1'b0);
      end
      if (j == 1) check("init_sig_seed", sig[id], MSEEDS[id]);
      if (j >= 1 && j <= pc) check("pat", pat[id], exp_pat_q.pop_front());
      if (j == last) begin
        check("done", done[id], 1'b1);
        check("busy_cycles", 16'(busy_n), 16'(last));
        check("sig", sig[id], exp_sig_q.pop_front());
        check("pass", pass[id], exp_pass_q.pop_front());
      end
      @(posedge ck); #1 rsp[id] = stim[j + 1];
    end
  endtask

  initial begin
    ck     = 1'b0;
    rstn   = 1'b0;
    start  = '1;
    mask_v = 6'h00;
    for (int i = 0; i < N; i++) rsp[i] = 6'h00;
    repeat (3) @(posedge ck);
    @(negedge ck);
    check("rst_busy", busy[0], 1'b0);
    check("rst_done", done[0], 1'b0);
    check("rst_pass", pass[0], 1'b0);
    check("rst_sig", sig[0], 16'h0000);
    check("rst_pat", pat[0], 3'b001);
    rstn = 1'b1;
    #1;
    check("rel_busy", busy[0], 1'b0);
    check("rel_sig", sig[0], 16'h0000);
    check("rel_pat", pat[0], 3'b001);
    start = '0;

    run(1, 2, -1);
    run(1, 2, -1);
    run(0, 0, -1);
    check("def_sig_zero", sig[0], 16'h0000);
    check("def_pass", pass[0], 1'b1);
    run(2, 1, -1);
    check("pc1_sig", sig[2], 16'h0001);
    check("pc1_pass_g0", pass[2], 1'b0);
    run(3, 1, -1);
    check("pc1_pass_g1", pass[3], 1'b1);
    run(4, 1, -1);
    check("lat2_sig", sig[4], 16'h0001);
    run(4, 1, -1);
    run(5, 2, 3);
    run(5, 3, -1);
    run(5, 3, -1);
    run(6, 0, -1);
    check("pc0_sig", sig[6], 16'hBEEF);
`ifdef BIST_X_MASK_EN
    mask_v = 6'h3F;
    run(2, 4, -1);
    check("mask_sig", sig[2], 16'h0000);
    mask_v = 6'h00;
`endif
    repeat (2) @(posedge ck);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
